// File: rtl/morse_pkg.sv
// Shared types and constants for the mode-0 Morse transmit scheduler.
// Imported by the scheduler top and its queue.
package morse_pkg;

  localparam int CLK_HZ     = 1_000_000;
  localparam int DELAY_2SEC = 2 * CLK_HZ;

  typedef struct packed {
    logic [7:0] ch;
    logic [4:0] code;
    logic [2:0] len;
  } morse_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_PLAY = 2'd2
  } sched_state_t;

endpackage

// File: rtl/morse_sched_fifo.sv
// Timestamped character queue with a ripe pointer that trails the
// write pointer by DELAY cycles, one entry ripening per cycle.
module morse_sched_fifo
  import morse_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DELAY = DELAY_2SEC,
  parameter int TS_W  = 22
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_push,
  input  morse_entry_t    i_entry,
  input  logic [TS_W-1:0] i_ts,
  input  logic            i_pop,
  output morse_entry_t    o_head,
  output logic            o_ready,
  output logic            o_full,
  output logic [AW:0]     o_count
);

  localparam logic [TS_W-1:0] DLY      = TS_W'(DELAY);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  // Pointers carry one extra wrap bit so a full queue of unripe
  // entries is distinguishable from an all-ripe one.
  logic [AW:0]     r_wr;
  logic [AW:0]     r_rd;
  logic [AW:0]     r_ripe;
  morse_entry_t    r_ent [DEPTH];
  logic [TS_W-1:0] r_tsm [DEPTH];

  logic [TS_W-1:0] w_age;
  logic            w_ripen;
  logic            w_wr_en;
  logic            w_rd_en;

  assign o_count = r_wr - r_rd;
  assign o_full  = (o_count == FULL_CNT);
  assign o_ready = (r_rd != r_ripe);
  assign o_head  = r_ent[r_rd[AW-1:0]];

  // Only the oldest unripe entry is aged, so the modular
  // difference never exceeds the timestamp range.
  assign w_age   = i_ts - r_tsm[r_ripe[AW-1:0]];
  assign w_ripen = (r_ripe != r_wr) && (w_age >= DLY);

  // Fullness is judged before any same-cycle pop.
  assign w_wr_en = i_push && !o_full && !i_flush;
  assign w_rd_en = i_pop && o_ready;

  // Entry and timestamp storage, no reset needed.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_ent[r_wr[AW-1:0]] <= i_entry;
      r_tsm[r_wr[AW-1:0]] <= i_ts;
    end
  end

  // Write, read and ripe pointers; flush empties the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_ripe <= '0;
    end else begin
      if (w_wr_en) r_wr   <= r_wr + 1'b1;
      if (w_rd_en) r_rd   <= r_rd + 1'b1;
      if (w_ripen) r_ripe <= r_ripe + 1'b1;
    end
  end

endmodule

// File: rtl/morse_tx_scheduler.sv
// Mode-0 transmit scheduler: delays each keyed character, then
// releases it to the LCD and serialises buzzer words via start/busy.
module morse_tx_scheduler
  import morse_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int DELAY   = DELAY_2SEC,
  parameter int TS_W    = 22,
  parameter int BUSY_TO = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  input  logic [4:0]  in_code,
  input  logic [2:0]  in_len,
  input  logic        buzzer_busy,
  output logic        buzzer_start,
  output logic        xfer_valid,
  output logic [7:0]  xfer_char,
  output logic [4:0]  xfer_code,
  output logic [2:0]  xfer_len,
  output logic [AW:0] count,
  output logic        overflow
);

  localparam int TO_W = $clog2(BUSY_TO + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);

  logic [TS_W-1:0] r_ts;
  sched_state_t    r_state;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_buzzer_start;
  logic            r_xfer_valid;
  logic [7:0]      r_xfer_char;
  logic [4:0]      r_xfer_code;
  logic [2:0]      r_xfer_len;
  logic            r_overflow;

  morse_entry_t    w_entry;
  morse_entry_t    w_head;
  logic            w_ready;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [AW:0]     w_count;

  assign w_entry = {in_char, in_code, in_len};
  assign w_push  = in_valid && enable;

  // A release needs an idle buzzer word slot, a ripe head and no
  // flush in the same cycle.
  assign w_pop = (r_state == ST_IDLE) && w_ready && enable
              && !buzzer_busy && !flush;

  morse_sched_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DELAY (DELAY),
    .TS_W  (TS_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_ts    (r_ts),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_ready (w_ready),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // Free-running timestamp, wraps modulo 2**TS_W.
  always_ff @(posedge clk) begin
    if (!rst_n) r_ts <= '0;
    else        r_ts <= r_ts + 1'b1;
  end

  // Release FSM with registered transfer, start and overflow pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_to_cnt       <= '0;
      r_buzzer_start <= 1'b0;
      r_xfer_valid   <= 1'b0;
      r_xfer_char    <= '0;
      r_xfer_code    <= '0;
      r_xfer_len     <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_buzzer_start <= 1'b0;
      r_xfer_valid   <= 1'b0;
      r_overflow     <= w_push && w_full && !flush;
      unique case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_xfer_valid <= 1'b1;
            r_xfer_char  <= w_head.ch;
            r_xfer_code  <= w_head.code;
            r_xfer_len   <= w_head.len;
            if (w_head.len != 3'd0) begin
              r_buzzer_start <= 1'b1;
              r_to_cnt       <= '0;
              r_state        <= ST_ARM;
            end
          end
        end
        ST_ARM: begin
          if (buzzer_busy)              r_state  <= ST_PLAY;
          else if (r_to_cnt == TO_LAST) r_state  <= ST_IDLE;
          else                          r_to_cnt <= r_to_cnt + 1'b1;
        end
        ST_PLAY: begin
          if (!buzzer_busy) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign buzzer_start = r_buzzer_start;
  assign xfer_valid   = r_xfer_valid;
  assign xfer_char    = r_xfer_char;
  assign xfer_code    = r_xfer_code;
  assign xfer_len     = r_xfer_len;
  assign overflow     = r_overflow;
  assign count        = w_count;

endmodule
